// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: owns the PC, addresses the combinational ROM and
// buffers {PC, Inst} pairs in a small prefetch FIFO that decode drains over valid/ready.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       fetch_en_i,
  input  logic                       redirect_i,
  input  logic [31:0]                redirect_pc_i,
  output logic [31:0]                addr_o,
  input  logic [31:0]                inst_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_inst_o,
  output logic [31:0]                out_pc_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      mem_pc_q   [DEPTH];
  logic [31:0]      mem_inst_q [DEPTH];

  logic out_valid;
  logic pop;
  logic push;

  assign out_valid = (count_q != '0);
  // Redirect wins over both ends: the flushed head must not count as consumed.
  assign pop  = out_valid & out_ready_i & ~redirect_i;
  assign push = fetch_en_i & ~redirect_i & ((count_q < DEPTH_C) | pop);

  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_i) begin
      pc_d     = redirect_pc_i & ~32'h3;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]   <= '0;
        mem_inst_q[i] <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        mem_pc_q[wr_ptr_q]   <= pc_q;
        mem_inst_q[wr_ptr_q] <= inst_i;
      end
    end
  end

  assign addr_o      = pc_q;
  assign out_valid_o = out_valid;
  assign out_inst_o  = mem_inst_q[rd_ptr_q];
  assign out_pc_o    = mem_pc_q[rd_ptr_q];
  assign count_o     = count_q;

endmodule
